// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX byte FIFO plus serialiser, combinational read port.
// Define UART_MMIO_RX_EN to build the receiver; without it the RX registers read as zero.
module uart_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [15:0] BAUD_DIV  = 16'd434,
  parameter int unsigned TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_i_daddr,
  input  logic [3:0]  bus_i_dwmask,
  input  logic [31:0] bus_i_dwdata,
  output logic [31:0] bus_o_drdata,
  output logic        bus_o_hit,
  output logic        uart_o_tx,
  input  logic        uart_i_rx
);
  localparam int unsigned PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_st_t;

  logic [1:0]    w_off;
  logic          w_push, w_rxd_wr, w_st_clr, w_div_lo, w_div_hi;
  logic [15:0]   r_div, w_div_eff, w_bit_rld;
  logic [7:0]    r_mem [TX_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_full, w_fifo_empty, w_pop, w_push_ok;
  logic          r_tx_ovf;
  tx_st_t        r_tx_st;
  logic [15:0]   r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_sh;
  logic          r_tx;
  logic          w_tx_busy, w_tx_empty;
  logic          w_rx_valid, w_rx_ovr, w_rx_ferr;
  logic [7:0]    w_rx_data;
  logic          w_unused;

  // Address decode; offset bits [1:0] are ignored.
  assign bus_o_hit = (bus_i_daddr[31:4] == BASE_ADDR[31:4]);
  assign w_off     = bus_i_daddr[3:2];
  assign w_push    = bus_o_hit && (w_off == 2'd0) && bus_i_dwmask[0];
  assign w_rxd_wr  = bus_o_hit && (w_off == 2'd1) && (bus_i_dwmask != 4'd0);
  assign w_st_clr  = bus_o_hit && (w_off == 2'd2) && bus_i_dwmask[0];
  assign w_div_lo  = bus_o_hit && (w_off == 2'd3) && bus_i_dwmask[0];
  assign w_div_hi  = bus_o_hit && (w_off == 2'd3) && bus_i_dwmask[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= BAUD_DIV;
    end else begin
      if (w_div_lo) r_div[7:0]  <= bus_i_dwdata[7:0];
      if (w_div_hi) r_div[15:8] <= bus_i_dwdata[15:8];
    end
  end

  assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_bit_rld = w_div_eff - 16'd1;

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign w_full       = (r_cnt == FULL_CNT);
  assign w_fifo_empty = (r_cnt == '0);
  assign w_pop        = !w_fifo_empty &&
                        ((r_tx_st == TX_IDLE) || ((r_tx_st == TX_STOP) && (r_tx_cnt == 16'd0)));
  assign w_push_ok    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp] <= bus_i_dwdata[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + PW'(1);
      if (w_pop)     r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(w_push_ok) - CW'(w_pop);
      if (w_push && !w_push_ok)            r_tx_ovf <= 1'b1;
      else if (w_st_clr && bus_i_dwdata[4]) r_tx_ovf <= 1'b0;
    end
  end

  // TX serialiser; every bit lasts the divisor sampled at its start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_st  <= TX_IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
      r_tx     <= 1'b1;
    end else begin
      case (r_tx_st)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_tx_sh  <= r_mem[r_rp];
            r_tx_cnt <= w_bit_rld;
            r_tx     <= 1'b0;
            r_tx_st  <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt == 16'd0) begin
            r_tx_cnt <= w_bit_rld;
            r_tx_bit <= 3'd0;
            r_tx     <= r_tx_sh[0];
            r_tx_st  <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == 16'd0) begin
            r_tx_cnt <= w_bit_rld;
            if (r_tx_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_tx_st <= TX_STOP;
            end else begin
              r_tx_bit <= r_tx_bit + 3'd1;
              r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
              r_tx     <= r_tx_sh[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (r_tx_cnt == 16'd0) begin
            if (w_pop) begin
              r_tx_sh  <= r_mem[r_rp];
              r_tx_cnt <= w_bit_rld;
              r_tx     <= 1'b0;
              r_tx_st  <= TX_START;
            end else begin
              r_tx_st <= TX_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
        default: r_tx_st <= TX_IDLE;
      endcase
    end
  end

  assign uart_o_tx  = r_tx;
  assign w_tx_busy  = (r_tx_st != TX_IDLE);
  assign w_tx_empty = w_fifo_empty && !w_tx_busy;

`ifdef UART_MMIO_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;

  rx_st_t      r_rx_st;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic [15:0] r_rx_cnt, w_half_rld;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_sh, r_rx_data;
  logic        r_rx_valid, r_rx_ovr, r_rx_ferr;
  logic        w_rx_done;

  assign w_half_rld = (w_div_eff < 16'd2) ? 16'd0 : ((w_div_eff >> 1) - 16'd1);
  assign w_rx_done  = (r_rx_st == RX_STOP) && (r_rx_cnt == 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= uart_i_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // RX deserialiser: half-bit delay to mid start bit, then one sample per bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_st  <= RX_IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
    end else begin
      case (r_rx_st)
        RX_IDLE: begin
          if (!r_rx_s2 && r_rx_prev) begin
            r_rx_cnt <= w_half_rld;
            r_rx_st  <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == 16'd0) begin
            if (r_rx_s2) begin
              r_rx_st <= RX_IDLE;
            end else begin
              r_rx_cnt <= w_bit_rld;
              r_rx_bit <= 3'd0;
              r_rx_st  <= RX_DATA;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == 16'd0) begin
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_cnt <= w_bit_rld;
            if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
            else                  r_rx_bit <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == 16'd0) r_rx_st  <= RX_IDLE;
          else                   r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        default: r_rx_st <= RX_IDLE;
      endcase
    end
  end

  // A completing byte beats a simultaneous RXDATA write and is then not an overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      if (w_rx_done) begin
        r_rx_data  <= r_rx_sh;
        r_rx_valid <= 1'b1;
      end else if (w_rxd_wr) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_done && r_rx_valid && !w_rxd_wr) r_rx_ovr <= 1'b1;
      else if (w_st_clr && bus_i_dwdata[5])      r_rx_ovr <= 1'b0;
      if (w_rx_done && !r_rx_s2)                 r_rx_ferr <= 1'b1;
      else if (w_st_clr && bus_i_dwdata[6])      r_rx_ferr <= 1'b0;
    end
  end

  assign w_rx_valid = r_rx_valid;
  assign w_rx_ovr   = r_rx_ovr;
  assign w_rx_ferr  = r_rx_ferr;
  assign w_rx_data  = r_rx_data;
  assign w_unused   = ^{bus_i_daddr[1:0], bus_i_dwdata[31:16]};
`else
  assign w_rx_valid = 1'b0;
  assign w_rx_ovr   = 1'b0;
  assign w_rx_ferr  = 1'b0;
  assign w_rx_data  = 8'd0;
  assign w_unused   = ^{uart_i_rx, w_rxd_wr, bus_i_daddr[1:0],
                        bus_i_dwdata[31:16], bus_i_dwdata[6:5]};
`endif

  always_comb begin
    bus_o_drdata = 32'd0;
    if (bus_o_hit) begin
      case (w_off)
        2'd0: bus_o_drdata = {31'd0, w_full};
        2'd1: bus_o_drdata = {w_rx_valid, 23'd0, w_rx_data};
        2'd2: bus_o_drdata = {25'd0, w_rx_ferr, w_rx_ovr, r_tx_ovf, w_rx_valid,
                              w_tx_busy, w_tx_empty, w_full};
        default: bus_o_drdata = {16'd0, r_div};
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed self-checking bench for uart_mmio (register map, TX framing, FIFO overflow, reset, optional RX).
`timescale 1ns/1ps
module tb_uart_mmio;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bus_i_daddr = 32'd0;
  logic [3:0]  bus_i_dwmask = 4'd0;
  logic [31:0] bus_i_dwdata = 32'd0;
  logic [31:0] bus_o_drdata;
  logic        bus_o_hit;
  logic        uart_o_tx;
  logic        uart_i_rx = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  uart_mmio #(.BASE_ADDR(BASE), .BAUD_DIV(16'd434), .TX_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .bus_i_daddr(bus_i_daddr), .bus_i_dwmask(bus_i_dwmask), .bus_i_dwdata(bus_i_dwdata),
    .bus_o_drdata(bus_o_drdata), .bus_o_hit(bus_o_hit),
    .uart_o_tx(uart_o_tx), .uart_i_rx(uart_i_rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] waddr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic        exp_hit;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; the write is captured at the next rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    bus_i_daddr  = a;
    bus_i_dwmask = m;
    bus_i_dwdata = d;
    @(negedge clk);
    bus_i_dwmask = 4'd0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus_i_daddr  = a;
    bus_i_dwmask = 4'd0;
    #1;
    check(name, 64'(bus_o_drdata), 64'(exp));
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k, input int d);
    int j;
    j = k / d;
    if (j == 0) return 1'b0;
    if (j >= 9) return 1'b1;
    return b[j-1];
  endfunction

  function automatic logic exp_stream(input int idx);
    if (idx < 1 || idx > 360) return 1'b1;
    return exp_bit(8'hA0 + 8'((idx - 1) / 40), (idx - 1) % 40, 4);
  endfunction

  // Push one byte, compare the whole frame, then confirm the transmitter went idle.
  task automatic send_check(input string name, input logic [7:0] b, input int d);
    int errs;
    errs = 0;
    bus_write(BASE, 4'h1, {24'd0, b});
    bus_i_daddr = BASE + 32'h8;
    check({name, "_pre"}, 64'(uart_o_tx), 64'd1);
    for (int k = 0; k < 10 * d; k++) begin
      @(negedge clk);
      if (uart_o_tx !== exp_bit(b, k, d)) errs++;
      if (k == 5 * d) check({name, "_busy"}, 64'(bus_o_drdata), 64'h4);
    end
    check({name, "_bits"}, 64'(errs), 64'd0);
    @(negedge clk);
    check({name, "_idle"}, 64'(bus_o_drdata), 64'h2);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      uart_i_rx = f[j];
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    int errs;
    vecs[0]  = '{1'b0, 32'd0, 4'h0, 32'd0, BASE + 32'h8, 1'b1, 32'h2, "rst_status"};
    vecs[1]  = '{1'b0, 32'd0, 4'h0, 32'd0, BASE + 32'hC, 1'b1, 32'h1B2, "rst_div"};
    vecs[2]  = '{1'b0, 32'd0, 4'h0, 32'd0, BASE, 1'b1, 32'h0, "rst_txdata"};
    vecs[3]  = '{1'b0, 32'd0, 4'h0, 32'd0, BASE + 32'h4, 1'b1, 32'h0, "rst_rxdata"};
    vecs[4]  = '{1'b1, BASE + 32'hC, 4'h1, 32'hDEAD_1234, BASE + 32'hC, 1'b1, 32'h134, "div_lo"};
    vecs[5]  = '{1'b1, BASE + 32'hC, 4'h2, 32'h0000_AB00, BASE + 32'hC, 1'b1, 32'hAB34, "div_hi"};
    vecs[6]  = '{1'b1, BASE + 32'hC, 4'h4, 32'hFFFF_FFFF, BASE + 32'hC, 1'b1, 32'hAB34, "div_upper_mask"};
    vecs[7]  = '{1'b1, 32'h2000_000C, 4'hF, 32'h0, BASE + 32'hC, 1'b1, 32'hAB34, "div_nohit_wr"};
    vecs[8]  = '{1'b0, 32'd0, 4'h0, 32'd0, 32'h2000_0008, 1'b0, 32'h0, "nohit_read"};
    vecs[9]  = '{1'b1, BASE + 32'hE, 4'h3, 32'h0, BASE + 32'hF, 1'b1, 32'h0, "div_zero"};
    vecs[10] = '{1'b1, BASE + 32'h8, 4'h1, 32'hFF, BASE + 32'h8, 1'b1, 32'h2, "status_w1c_idle"};
    vecs[11] = '{1'b1, BASE + 32'h4, 4'hF, 32'h0, BASE + 32'h4, 1'b1, 32'h0, "rxdata_wr"};

    #2 rst = 1'b0;
    #1 check("rst_tx", 64'(uart_o_tx), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].waddr, vecs[i].mask, vecs[i].wdata);
      bus_i_daddr = vecs[i].raddr;
      #1;
      check(vecs[i].name, 64'({bus_o_hit, bus_o_drdata}), 64'({vecs[i].exp_hit, vecs[i].exp}));
      @(negedge clk);
    end

    // DIV=0 behaves as a divisor of 1
    send_check("div0_frame", 8'h0F, 1);
    bus_write(BASE + 32'hC, 4'h3, 32'd4);
    send_check("tx55_frame", 8'h55, 4);

    // Ten consecutive pushes: nine frames back-to-back, the tenth dropped
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      bus_i_daddr  = BASE;
      bus_i_dwmask = 4'h1;
      bus_i_dwdata = 32'(8'hA0 + 8'(i));
      @(negedge clk);
      if (uart_o_tx !== exp_stream(i)) errs++;
    end
    bus_i_dwmask = 4'h0;
    rd_check("burst_full", BASE + 32'h8, 32'h15);
    rd_check("burst_txdata_full", BASE, 32'h1);
    for (int idx = 10; idx < 370; idx++) begin
      @(negedge clk);
      if (uart_o_tx !== exp_stream(idx)) errs++;
    end
    check("burst_stream", 64'(errs), 64'd0);
    rd_check("burst_ovf", BASE + 32'h8, 32'h12);
    @(negedge clk);
    bus_write(BASE + 32'h8, 4'h1, 32'h10);
    rd_check("ovf_clear", BASE + 32'h8, 32'h2);
    @(negedge clk);

`ifdef UART_MMIO_RX_EN
    bus_write(BASE + 32'hC, 4'h3, 32'd8);
    rx_frame(8'hA3, 1'b1);
    repeat (4) @(negedge clk);
    rd_check("rx_byte", BASE + 32'h4, 32'h8000_00A3);
    rd_check("rx_status", BASE + 32'h8, 32'h0A);
    @(negedge clk);
    rx_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    rd_check("rx_ovr_status", BASE + 32'h8, 32'h2A);
    rd_check("rx_ovr_data", BASE + 32'h4, 32'h8000_003C);
    @(negedge clk);
    bus_write(BASE + 32'h4, 4'h1, 32'h0);
    bus_write(BASE + 32'h8, 4'h1, 32'h60);
    rd_check("rx_clear", BASE + 32'h8, 32'h2);
    @(negedge clk);
    uart_i_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_i_rx = 1'b1;
    repeat (30) @(negedge clk);
    rd_check("glitch_status", BASE + 32'h8, 32'h2);
    rd_check("glitch_data", BASE + 32'h4, 32'h0000_003C);
    @(negedge clk);
    rx_frame(8'h5A, 1'b0);
    uart_i_rx = 1'b1;
    repeat (4) @(negedge clk);
    rd_check("ferr_status", BASE + 32'h8, 32'h4A);
    rd_check("ferr_data", BASE + 32'h4, 32'h8000_005A);
    @(negedge clk);
    bus_write(BASE + 32'h4, 4'h1, 32'h0);
    bus_write(BASE + 32'h8, 4'h1, 32'h60);
    bus_write(BASE + 32'hC, 4'h3, 32'd4);
`else
    bus_write(BASE + 32'hC, 4'h3, 32'd8);
    rx_frame(8'hA3, 1'b1);
    repeat (4) @(negedge clk);
    rd_check("rx_disabled_data", BASE + 32'h4, 32'h0);
    rd_check("rx_disabled_status", BASE + 32'h8, 32'h2);
    @(negedge clk);
    bus_write(BASE + 32'hC, 4'h3, 32'd4);
`endif

    // Reset in the middle of a frame with a second byte still queued
    bus_write(BASE, 4'h1, 32'h00);
    bus_write(BASE, 4'h1, 32'h00);
    repeat (8) @(negedge clk);
    check("pre_rst_tx", 64'(uart_o_tx), 64'd0);
    rst = 1'b0;
    #1 check("rst_mid_tx", 64'(uart_o_tx), 64'd1);
    rd_check("rst_mid_status", BASE + 32'h8, 32'h2);
    @(negedge clk);
    rst = 1'b1;
    rd_check("post_rst_status", BASE + 32'h8, 32'h2);
    rd_check("post_rst_div", BASE + 32'hC, 32'h1B2);
    errs = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (uart_o_tx !== 1'b1) errs++;
    end
    check("post_rst_idle", 64'(errs), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
